usb_rx_packet_parser: RTL and testbench

Consumer stage directly downstream of the USB receiver's RX FIFO. Pops received bytes, with SYNC already stripped, from the FIFO one per cycle. Validates the PID byte and classifies the packet as token, data or handshake. Extracts token fields, streams data-packet bytes, and reports exactly one packet-complete or packet-error pulse per packet.

---
 rtl/usb_rx_packet_parser.sv | 160 ++++++++++++++++
 tb/tb_usb_rx_packet_parser.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_parser.sv
// Pops SYNC-stripped bytes from the USB RX FIFO, validates/classifies the PID, extracts token
// fields, streams DATA bytes and reports exactly one pkt_done or pkt_error per packet.
module usb_rx_packet_parser #(
  parameter int MAX_DATA_BYTES = 66
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  r_data,
  input  logic        empty,
  input  logic        rcving,
  input  logic        r_error,
  output logic        r_enable,
  output logic        pkt_start,
  output logic [3:0]  pid,
  output logic        token_valid,
  output logic [6:0]  token_addr,
  output logic [3:0]  token_endp,
  output logic [10:0] frame_num,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        pkt_done,
  output logic        pkt_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DATA, S_HSHAKE, S_DRAIN, S_END
  } state_t;

  state_t      state_q;
  logic [6:0]  cnt_q;
  logic        err_q;
  logic [7:0]  b1_q;
  logic        pkt_start_q, token_valid_q, data_valid_q, pkt_done_q, pkt_error_q;
  logic [3:0]  pid_q, token_endp_q;
  logic [6:0]  token_addr_q;
  logic [10:0] frame_num_q;
  logic [7:0]  data_out_q;

  logic pid_ok;
  logic end_cond;

  assign pid_ok   = (r_data[7:4] == ~r_data[3:0]) && (r_data[1:0] != 2'b00);
  assign end_cond = !rcving && empty;
  // Every state except the one-cycle END slot consumes bytes, including DRAIN and HSHAKE.
  assign r_enable = (state_q != S_END) && !empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      b1_q          <= '0;
      pkt_start_q   <= 1'b0;
      pid_q         <= '0;
      token_valid_q <= 1'b0;
      token_addr_q  <= '0;
      token_endp_q  <= '0;
      frame_num_q   <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_error_q   <= 1'b0;
    end else begin
      pkt_start_q   <= 1'b0;
      token_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_error_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pkt_start_q <= 1'b1;
            pid_q       <= r_data[3:0];
            cnt_q       <= '0;
            if (!pid_ok) begin
              err_q   <= 1'b1;
              state_q <= S_DRAIN;
            end else begin
              case (r_data[1:0])
                2'b01:   state_q <= S_TOKEN;
                2'b11:   state_q <= S_DATA;
                default: state_q <= S_HSHAKE;
              endcase
            end
          end
        end
        S_TOKEN: begin
          if (!empty) begin
            if (cnt_q == 7'd0) begin
              token_addr_q <= r_data[6:0];
              b1_q         <= r_data;
              cnt_q        <= 7'd1;
            end else if (cnt_q == 7'd1) begin
              token_endp_q  <= {r_data[2:0], b1_q[7]};
              frame_num_q   <= {r_data[2:0], b1_q};
              token_valid_q <= 1'b1;
              cnt_q         <= 7'd2;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_DRAIN;
            end
          end else if (end_cond) begin
            if (cnt_q != 7'd2 || r_error) err_q <= 1'b1;
            state_q <= S_END;
          end
        end
        S_DATA: begin
          if (!empty) begin
            if (cnt_q < 7'(MAX_DATA_BYTES)) begin
              data_out_q   <= r_data;
              data_valid_q <= 1'b1;
              cnt_q        <= cnt_q + 7'd1;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_DRAIN;
            end
          end else if (end_cond) begin
            if (cnt_q < 7'd2 || r_error) err_q <= 1'b1;
            state_q <= S_END;
          end
        end
        S_HSHAKE: begin
          if (!empty) begin
            err_q   <= 1'b1;
            state_q <= S_DRAIN;
          end else if (end_cond) begin
            if (r_error) err_q <= 1'b1;
            state_q <= S_END;
          end
        end
        S_DRAIN: begin
          if (end_cond) begin
            if (r_error) err_q <= 1'b1;
            state_q <= S_END;
          end
        end
        S_END: begin
          pkt_error_q <= err_q;
          pkt_done_q  <= !err_q;
          err_q       <= 1'b0;
          cnt_q       <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pkt_start   = pkt_start_q;
  assign pid         = pid_q;
  assign token_valid = token_valid_q;
  assign token_addr  = token_addr_q;
  assign token_endp  = token_endp_q;
  assign frame_num   = frame_num_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_error   = pkt_error_q;

endmodule

// File: tb/tb_usb_rx_packet_parser.sv
// Directed bench for usb_rx_packet_parser: a queue models the RX FIFO, pulses are tallied per packet.
module tb_usb_rx_packet_parser;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  r_data = 8'h00;
  logic        empty = 1'b1;
  logic        rcving = 1'b0;
  logic        r_error = 1'b0;
  logic        r_enable;
  logic        pkt_start;
  logic [3:0]  pid;
  logic        token_valid;
  logic [6:0]  token_addr;
  logic [3:0]  token_endp;
  logic [10:0] frame_num;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        pkt_done;
  logic        pkt_error;

  usb_rx_packet_parser #(.MAX_DATA_BYTES(66)) dut (
    .clk(clk), .n_rst(n_rst), .r_data(r_data), .empty(empty), .rcving(rcving),
    .r_error(r_error), .r_enable(r_enable), .pkt_start(pkt_start), .pid(pid),
    .token_valid(token_valid), .token_addr(token_addr), .token_endp(token_endp),
    .frame_num(frame_num), .data_out(data_out), .data_valid(data_valid),
    .pkt_done(pkt_done), .pkt_error(pkt_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  data_q[$];
  int          n_start, n_tv, n_done, n_err;
  logic [3:0]  pid_seen;
  logic [6:0]  addr_seen;
  logic [3:0]  endp_seen;
  logic [10:0] frame_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    data_q.delete();
    n_start = 0; n_tv = 0; n_done = 0; n_err = 0;
    pid_seen = '0; addr_seen = '0; endp_seen = '0; frame_seen = '0;
  endtask

  // One clock: present the FIFO head, pop on the edge if the DUT asked, tally outputs after the edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    empty  = (fifo_q.size() == 0);
    r_data = empty ? 8'h00 : fifo_q[0];
    rcving = !empty;
    #1 pop = r_enable;
    @(posedge clk);
    #1;
    if (pop) void'(fifo_q.pop_front());
    if (pkt_start) begin n_start++; pid_seen = pid; end
    if (token_valid) begin
      n_tv++; addr_seen = token_addr; endp_seen = token_endp; frame_seen = frame_num;
    end
    if (data_valid) data_q.push_back(data_out);
    if (pkt_done) n_done++;
    if (pkt_error) n_err++;
  endtask

  task automatic run_pkt(input string tag);
    int budget;
    clear_stats();
    budget = 0;
    while (n_done + n_err == 0 && budget < 300) begin
      step();
      budget++;
    end
    if (n_done + n_err == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
    repeat (3) step();
    check({tag, "_start"}, 64'(n_start), 64'd1);
  endtask

  initial begin
    logic [31:0] cat;

    // Reset state with FIFO empty
    #12;
    check("reset_outputs",
          {24'd0, r_enable, pkt_start, pid, token_valid, token_addr, token_endp, frame_num,
           data_out, data_valid, pkt_done, pkt_error}, 64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // OUT token, addr 5 endp 1
    fifo_q = '{8'hE1, 8'h85, 8'h10};
    run_pkt("out");
    check("out_pid", 64'(pid_seen), 64'h1);
    check("out_tv", 64'(n_tv), 64'd1);
    check("out_addr", 64'(addr_seen), 64'h05);
    check("out_endp", 64'(endp_seen), 64'h1);
    check("out_done_err", {32'(n_done), 32'(n_err)}, {32'd1, 32'd0});

    // SOF frame 0x234
    fifo_q = '{8'hA5, 8'h34, 8'h02};
    run_pkt("sof");
    check("sof_frame", 64'(frame_seen), 64'h234);
    check("sof_tv", 64'(n_tv), 64'd1);
    check("sof_done_err", {32'(n_done), 32'(n_err)}, {32'd1, 32'd0});

    // DATA0 with four bytes
    fifo_q = '{8'hC3, 8'h11, 8'h22, 8'hAA, 8'hBB};
    run_pkt("data0");
    check("data0_count", 64'(data_q.size()), 64'd4);
    cat = '0;
    foreach (data_q[i]) cat = {cat[23:0], data_q[i]};
    check("data0_bytes", 64'(cat), 64'h1122AABB);
    check("data0_done_err", {32'(n_done), 32'(n_err)}, {32'd1, 32'd0});

    // ACK alone, then ACK followed by a stray byte
    fifo_q = '{8'hD2};
    run_pkt("ack");
    check("ack_pid", 64'(pid_seen), 64'h2);
    check("ack_no_data", 64'(data_q.size()), 64'd0);
    check("ack_done_err", {32'(n_done), 32'(n_err)}, {32'd1, 32'd0});
    fifo_q = '{8'hD2, 8'h00};
    run_pkt("ack_long");
    check("ack_long_done_err", {32'(n_done), 32'(n_err)}, {32'd0, 32'd1});

    // Bad PID complement, then a truncated token
    fifo_q = '{8'hE2, 8'h11, 8'h22};
    run_pkt("badpid");
    check("badpid_done_err", {32'(n_done), 32'(n_err)}, {32'd0, 32'd1});
    check("badpid_fifo_drained", 64'(fifo_q.size()), 64'd0);
    fifo_q = '{8'hE1, 8'h85};
    run_pkt("shorttok");
    check("shorttok_done_err", {32'(n_done), 32'(n_err)}, {32'd0, 32'd1});

    // DATA with a single byte after the PID is too short
    fifo_q = '{8'hC3, 8'h55};
    run_pkt("data_short");
    check("data_short_done_err", {32'(n_done), 32'(n_err)}, {32'd0, 32'd1});

    // DATA1 with exactly 66 bytes is legal
    fifo_q = '{8'h4B};
    for (int i = 1; i <= 66; i++) fifo_q.push_back(8'(i));
    run_pkt("data66");
    check("data66_count", 64'(data_q.size()), 64'd66);
    check("data66_done_err", {32'(n_done), 32'(n_err)}, {32'd1, 32'd0});

    // DATA1 with 67 bytes: 66 forwarded, then error
    fifo_q = '{8'h4B};
    for (int i = 1; i <= 67; i++) fifo_q.push_back(8'(i));
    run_pkt("data67");
    check("data67_count", 64'(data_q.size()), 64'd66);
    check("data67_last", 64'(data_q.size() == 66 ? data_q[65] : 8'h00), 64'h42);
    check("data67_done_err", {32'(n_done), 32'(n_err)}, {32'd0, 32'd1});

    // Receiver error flagged on an otherwise valid ACK
    r_error = 1'b1;
    fifo_q = '{8'hD2};
    run_pkt("rerr");
    check("rerr_done_err", {32'(n_done), 32'(n_err)}, {32'd0, 32'd1});
    r_error = 1'b0;

    // Asynchronous reset in the middle of a DATA packet
    clear_stats();
    fifo_q = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    repeat (4) step();
    check("midrst_before_dv", 64'(data_valid), 64'd1);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_outputs",
          {25'd0, pkt_start, pid, token_valid, token_addr, token_endp, frame_num,
           data_out, data_valid, pkt_done, pkt_error}, 64'd0);
    fifo_q.delete();
    repeat (2) step();
    check("midrst_no_end_pulse", 64'(n_done + n_err), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    fifo_q = '{8'hE1, 8'h85, 8'h10};
    run_pkt("after_rst");
    check("after_rst_addr", 64'(addr_seen), 64'h05);
    check("after_rst_done_err", {32'(n_done), 32'(n_err)}, {32'd1, 32'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
